// File: rtl/prio_branch_pipe.sv
// Two-stage elastic priority branch evaluator: stage 1 captures the branch inputs,
// stage 2 registers the lowest-index winning branch, or the default/held value.
module prio_branch_pipe #(
    parameter  int unsigned N  = 4,
    parameter  int unsigned W  = 2,
    parameter  int unsigned CW = 8,
    localparam int unsigned SW = $clog2(N + 1)
) (
    input  logic            _clock,
    input  logic            _reset,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [N-1:0]    cond,
    input  logic [N*W-1:0]  val,
    input  logic [W-1:0]    dflt,
    input  logic            hold_mode,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [W-1:0]    out_data,
    output logic [SW-1:0]   out_sel,
    output logic            out_hit,
    output logic [CW-1:0]   dflt_count
);

    localparam logic [CW-1:0] CNT_MAX = {CW{1'b1}};

    logic           s1_valid;
    logic [N-1:0]   s1_cond;
    logic [N*W-1:0] s1_val;
    logic [W-1:0]   s1_dflt;
    logic           s1_hold;
    logic [W-1:0]   last_data;

    logic           s1_load_c;
    logic           s2_load_c;
    logic [W-1:0]   res_data_c;
    logic [SW-1:0]  res_sel_c;
    logic           res_hit_c;

    // Stage 2 drains when empty or when the consumer takes the current result.
    assign s2_load_c = s1_valid && (!out_valid || out_ready);
    assign in_ready  = !s1_valid || s2_load_c;
    assign s1_load_c = in_valid && in_ready;

    // Scan from the lowest priority upward so the lowest set index wins.
    always_comb begin
        res_data_c = s1_hold ? last_data : s1_dflt;
        res_sel_c  = SW'(N);
        res_hit_c  = 1'b0;
        for (int i = int'(N) - 1; i >= 0; i--) begin
            if (s1_cond[i]) begin
                res_data_c = s1_val[i*W +: W];
                res_sel_c  = SW'(i);
                res_hit_c  = 1'b1;
            end
        end
    end

    // Stage 1 payload carries no reset; it is qualified by s1_valid.
    always_ff @(posedge _clock) begin
        if (s1_load_c) begin
            s1_cond <= cond;
            s1_val  <= val;
            s1_dflt <= dflt;
            s1_hold <= hold_mode;
        end
    end

    always_ff @(posedge _clock) begin
        if (_reset) begin
            s1_valid   <= 1'b0;
            out_valid  <= 1'b0;
            out_data   <= '0;
            out_sel    <= '0;
            out_hit    <= 1'b0;
            last_data  <= '0;
            dflt_count <= '0;
        end else begin
            if (s1_load_c) begin
                s1_valid <= 1'b1;
            end else if (s2_load_c) begin
                s1_valid <= 1'b0;
            end

            if (s2_load_c) begin
                out_valid <= 1'b1;
                out_data  <= res_data_c;
                out_sel   <= res_sel_c;
                out_hit   <= res_hit_c;
                last_data <= res_data_c;
                if (!res_hit_c && dflt_count != CNT_MAX) begin
                    dflt_count <= dflt_count + CW'(1);
                end
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule
